// File: rtl/btn_event.sv
// Gesture decoder: short press, long press, double click and optional auto-repeat (BTN_REPEAT_EN).
// Latency 1 cycle (registered pulses); no backpressure, events are fire-and-forget one-cycle pulses.
module btn_event #(
    parameter int                CNT_W         = 24,
    parameter logic [CNT_W-1:0]  LONG_CYCLES   = 24'd5_000_000,
    parameter logic [CNT_W-1:0]  GAP_CYCLES    = 24'd3_000_000,
    parameter logic [CNT_W-1:0]  REPEAT_CYCLES = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic pressed
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        HELD   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] LONG_LAST = LONG_CYCLES - CNT_ONE;
    localparam logic [CNT_W-1:0] GAP_LAST  = GAP_CYCLES - CNT_ONE;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             short_q;
    logic             long_q;
    logic             dbl_q;
    logic             pressed_q;

`ifdef BTN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = REPEAT_CYCLES - CNT_ONE;
    logic rep_q;
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    // Counter is cleared on every state change, so equality compares never see a wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
            pressed_q <= 1'b0;
`ifdef BTN_REPEAT_EN
            rep_q     <= 1'b0;
`endif
        end else begin
            pressed_q <= ~btn_n;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
`ifdef BTN_REPEAT_EN
            rep_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (!btn_n) begin
                        state_q <= PRESS1;
                        cnt_q   <= CNT_ONE;
                    end
                end
                PRESS1: begin
                    if (!btn_n) begin
                        if (cnt_q == LONG_LAST) begin
                            long_q  <= 1'b1;
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end else begin
                        state_q <= GAP;
                        cnt_q   <= CNT_ONE;
                    end
                end
                GAP: begin
                    if (!btn_n) begin
                        dbl_q   <= 1'b1;
                        state_q <= PRESS2;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        short_q <= 1'b1;
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESS2: begin
                    if (btn_n) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                HELD: begin
                    if (btn_n) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
`ifdef BTN_REPEAT_EN
                    else if (cnt_q == REP_LAST) begin
                        rep_q <= 1'b1;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign pressed      = pressed_q;
`ifdef BTN_REPEAT_EN
    assign repeat_tick  = rep_q;
`else
    assign repeat_tick  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event with LONG=8, GAP=4, REPEAT=3.
// Observed vector per cycle: {short_press, long_press, double_click, repeat_tick, pressed}.
module tb_btn_event;

    logic clk;
    logic rst_n;
    logic btn_n;
    logic short_press;
    logic long_press;
    logic double_click;
    logic repeat_tick;
    logic pressed;

    int checks;
    int failures;

`ifdef BTN_REPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    btn_event #(
        .CNT_W         (24),
        .LONG_CYCLES   (24'd8),
        .GAP_CYCLES    (24'd4),
        .REPEAT_CYCLES (24'd3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_n        (btn_n),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_tick  (repeat_tick),
        .pressed      (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a level, take one rising edge, land 1 time unit after it.
    task automatic cyc(input logic b);
        btn_n = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [4:0] exp;
        for (int i = 0; i < 4; i++) begin
            cyc(i[0]);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== 5'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=00000", i,
                         {short_press, long_press, double_click, repeat_tick, pressed});
            end
        end
        rst_n = 1'b1;
        // high, one low (enters PRESS1), then highs until the short press resolves
        for (int i = 0; i < 6; i++) begin
            logic b;
            b   = (i == 1) ? 1'b0 : 1'b1;
            exp = {(i == 5), 1'b0, 1'b0, 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    task automatic test_short;
        logic [4:0] exp;
        logic       b;
        for (int i = 0; i < 9; i++) begin
            b   = (i < 3) ? 1'b0 : 1'b1;
            exp = {(i == 6), 1'b0, 1'b0, 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL short cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    task automatic test_double_click;
        logic [4:0] exp;
        logic       b;
        for (int i = 0; i < 18; i++) begin
            b   = ((i < 3) || (i >= 5 && i < 8)) ? 1'b0 : 1'b1;
            exp = {1'b0, 1'b0, (i == 5), 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL double cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    task automatic test_long_boundary;
        logic [4:0] exp;
        logic       b;
        for (int i = 0; i < 17; i++) begin
            b   = (i < 7) ? 1'b0 : 1'b1;
            exp = {(i == 10), 1'b0, 1'b0, 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL press7 cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
        for (int i = 0; i < 14; i++) begin
            b   = (i < 8) ? 1'b0 : 1'b1;
            exp = {1'b0, (i == 7), 1'b0, 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL press8 cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    task automatic test_repeat;
        logic [4:0] exp;
        logic       b;
        for (int i = 0; i < 19; i++) begin
            b   = (i < 15) ? 1'b0 : 1'b1;
            exp = {1'b0, (i == 7), 1'b0, REP_ON && (i == 10 || i == 13), ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL repeat cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    // Second press held long must not fire long/repeat; minimum gap still a double click.
    task automatic test_press2;
        logic [4:0] exp;
        logic       b;
        for (int i = 0; i < 18; i++) begin
            b   = (i < 3 || (i >= 4 && i < 16)) ? 1'b0 : 1'b1;
            exp = {1'b0, 1'b0, (i == 4), 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL press2_hold cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
        for (int i = 0; i < 12; i++) begin
            b   = (i < 2 || i == 5) ? 1'b0 : 1'b1;
            exp = {1'b0, 1'b0, (i == 5), 1'b0, ~b};
            cyc(b);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL gap3 cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [4:0] exp;
        for (int i = 0; i < 5; i++) begin
            exp = 5'b00001;
            cyc(1'b0);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== exp) begin
                failures++;
                $display("FAIL abort_press cyc=%0d got=%b exp=%b", i,
                         {short_press, long_press, double_click, repeat_tick, pressed}, exp);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({short_press, long_press, double_click, repeat_tick, pressed} !== 5'b0) begin
            failures++;
            $display("FAIL abort_async got=%b exp=00000",
                     {short_press, long_press, double_click, repeat_tick, pressed});
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== 5'b0) begin
                failures++;
                $display("FAIL abort_inreset cyc=%0d got=%b exp=00000", i,
                         {short_press, long_press, double_click, repeat_tick, pressed});
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1);
            checks++;
            if ({short_press, long_press, double_click, repeat_tick, pressed} !== 5'b0) begin
                failures++;
                $display("FAIL abort_after cyc=%0d got=%b exp=00000", i,
                         {short_press, long_press, double_click, repeat_tick, pressed});
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        btn_n    = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_short();
        test_double_click();
        test_long_boundary();
        test_repeat();
        test_press2();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
